// File: rtl/dram_sc_rep_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dram_sc_rep_pipe
// Brief    : DEPTH-stage pipelined repeater for the DRAM-to-L2 read-return
//            path. Payload flops load only on valid beats. Acks are staged
//            every cycle. An output-side checker flags bursts that arrive out
//            of order or with a changed request id.
// Options  : DRAM_REP_BEAT_CNT_EN adds saturating beat_cnt / mecc_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module dram_sc_rep_pipe #(
  parameter int DATA_W = 128,
  parameter int ECC_W  = 28,
  parameter int DEPTH  = 2,
  parameter int BEATS  = 4
) (
  input  logic                       rclk,
  input  logic                       arst,
  input  logic                       in_vld,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [ECC_W-1:0]           in_ecc,
  input  logic [$clog2(BEATS)-1:0]   in_chunk_id,
  input  logic [2:0]                 in_req_id,
  input  logic                       in_secc_err,
  input  logic                       in_mecc_err,
  input  logic                       in_rd_ack,
  input  logic                       in_wr_ack,
  input  logic                       seq_err_clr,
  output logic                       out_vld,
  output logic [DATA_W-1:0]          out_data,
  output logic [ECC_W-1:0]           out_ecc,
  output logic [$clog2(BEATS)-1:0]   out_chunk_id,
  output logic [2:0]                 out_req_id,
  output logic                       out_secc_err,
  output logic                       out_mecc_err,
  output logic                       out_rd_ack,
  output logic                       out_wr_ack,
`ifdef DRAM_REP_BEAT_CNT_EN
  output logic [15:0]                beat_cnt,
  output logic [15:0]                mecc_cnt,
`endif
  output logic                       seq_err
);

  localparam int            CW   = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  // Stage storage; index 0 is closest to the DRAM controller.
  logic              vld_q   [DEPTH];
  logic              rd_q    [DEPTH];
  logic              wr_q    [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [ECC_W-1:0]  ecc_q   [DEPTH];
  logic [CW-1:0]     chunk_q [DEPTH];
  logic [2:0]        id_q    [DEPTH];
  logic              secc_q  [DEPTH];
  logic              mecc_q  [DEPTH];

  // Control path: valids and acks advance every cycle, ungated.
  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < DEPTH; k++) begin
        vld_q[k] <= 1'b0;
        rd_q[k]  <= 1'b0;
        wr_q[k]  <= 1'b0;
      end
    end else begin
      vld_q[0] <= in_vld;
      rd_q[0]  <= in_rd_ack;
      wr_q[0]  <= in_wr_ack;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        rd_q[k]  <= rd_q[k-1];
        wr_q[k]  <= wr_q[k-1];
      end
    end
  end

  // Payload path: each stage loads only when the stage feeding it holds a valid beat.
  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k]  <= '0;
        ecc_q[k]   <= '0;
        chunk_q[k] <= '0;
        id_q[k]    <= '0;
        secc_q[k]  <= 1'b0;
        mecc_q[k]  <= 1'b0;
      end
    end else begin
      if (in_vld) begin
        data_q[0]  <= in_data;
        ecc_q[0]   <= in_ecc;
        chunk_q[0] <= in_chunk_id;
        id_q[0]    <= in_req_id;
        secc_q[0]  <= in_secc_err;
        mecc_q[0]  <= in_mecc_err;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (vld_q[k-1]) begin
          data_q[k]  <= data_q[k-1];
          ecc_q[k]   <= ecc_q[k-1];
          chunk_q[k] <= chunk_q[k-1];
          id_q[k]    <= id_q[k-1];
          secc_q[k]  <= secc_q[k-1];
          mecc_q[k]  <= mecc_q[k-1];
        end
      end
    end
  end

  assign out_vld      = vld_q[DEPTH-1];
  assign out_rd_ack   = rd_q[DEPTH-1];
  assign out_wr_ack   = wr_q[DEPTH-1];
  assign out_data     = data_q[DEPTH-1];
  assign out_ecc      = ecc_q[DEPTH-1];
  assign out_chunk_id = chunk_q[DEPTH-1];
  assign out_req_id   = id_q[DEPTH-1];
  // Error flags in the last stage may be stale while invalid; mask them.
  assign out_secc_err = secc_q[DEPTH-1] & vld_q[DEPTH-1];
  assign out_mecc_err = mecc_q[DEPTH-1] & vld_q[DEPTH-1];

  // ---------------------------------------------------------------------------
  // Burst-order checker on the output side
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] exp_chunk;
  logic [2:0]    cap_id;
  logic          viol;

  // A violation is any output beat that does not continue the current burst.
  always_comb begin
    viol = 1'b0;
    if (out_vld) begin
      if (state == IDLE) viol = (out_chunk_id != '0);
      else               viol = (out_chunk_id != exp_chunk) || (out_req_id != cap_id);
    end
  end

  // Checker FSM with sticky error; a new violation outranks a clear.
  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      exp_chunk <= '0;
      cap_id    <= '0;
      seq_err   <= 1'b0;
    end else begin
      if (viol)             seq_err <= 1'b1;
      else if (seq_err_clr) seq_err <= 1'b0;

      if (out_vld) begin
        case (state)
          IDLE: begin
            if (out_chunk_id == '0) begin
              cap_id    <= out_req_id;
              exp_chunk <= CW'(1);
              state     <= BURST;
            end
          end
          BURST: begin
            if (!viol) begin
              if (exp_chunk == LAST) begin
                state     <= IDLE;
                exp_chunk <= '0;
              end else begin
                exp_chunk <= exp_chunk + CW'(1);
              end
            end else if (out_chunk_id == '0) begin
              // Early chunk 0: abandon the old burst and track the new one.
              cap_id    <= out_req_id;
              exp_chunk <= CW'(1);
            end else begin
              state     <= IDLE;
              exp_chunk <= '0;
            end
          end
          default: begin
            state     <= IDLE;
            exp_chunk <= '0;
          end
        endcase
      end
    end
  end

`ifdef DRAM_REP_BEAT_CNT_EN
  // Saturating beat and multi-bit-error counters; clear outranks increment.
  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      beat_cnt <= '0;
      mecc_cnt <= '0;
    end else if (seq_err_clr) begin
      beat_cnt <= '0;
      mecc_cnt <= '0;
    end else begin
      if (out_vld && (beat_cnt != 16'hFFFF))      beat_cnt <= beat_cnt + 16'd1;
      if (out_mecc_err && (mecc_cnt != 16'hFFFF)) mecc_cnt <= mecc_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dram_sc_rep_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_sc_rep_pipe
// Brief    : Self-checking bench for dram_sc_rep_pipe with a queue-based
//            reference model of the pipe and the burst-order rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_sc_rep_pipe;

  localparam int DATA_W = 128;
  localparam int ECC_W  = 28;
  localparam int DEPTH  = 2;
  localparam int BEATS  = 4;
  localparam int CW     = 2;
  localparam int VW     = 1 + DATA_W + ECC_W + CW + 3 + 5;

  logic              rclk = 1'b0;
  logic              arst;
  logic              in_vld, in_secc_err, in_mecc_err, in_rd_ack, in_wr_ack, seq_err_clr;
  logic [DATA_W-1:0] in_data;
  logic [ECC_W-1:0]  in_ecc;
  logic [CW-1:0]     in_chunk_id;
  logic [2:0]        in_req_id;

  wire               out_vld, out_secc_err, out_mecc_err, out_rd_ack, out_wr_ack, seq_err;
  wire [DATA_W-1:0]  out_data;
  wire [ECC_W-1:0]   out_ecc;
  wire [CW-1:0]      out_chunk_id;
  wire [2:0]         out_req_id;
`ifdef DRAM_REP_BEAT_CNT_EN
  wire [15:0]        beat_cnt, mecc_cnt;
`endif

  int checks = 0;
  int errors = 0;

  dram_sc_rep_pipe #(.DATA_W(DATA_W), .ECC_W(ECC_W), .DEPTH(DEPTH), .BEATS(BEATS)) dut (
    .rclk(rclk), .arst(arst), .in_vld(in_vld), .in_data(in_data), .in_ecc(in_ecc),
    .in_chunk_id(in_chunk_id), .in_req_id(in_req_id), .in_secc_err(in_secc_err),
    .in_mecc_err(in_mecc_err), .in_rd_ack(in_rd_ack), .in_wr_ack(in_wr_ack),
    .seq_err_clr(seq_err_clr), .out_vld(out_vld), .out_data(out_data), .out_ecc(out_ecc),
    .out_chunk_id(out_chunk_id), .out_req_id(out_req_id), .out_secc_err(out_secc_err),
    .out_mecc_err(out_mecc_err), .out_rd_ack(out_rd_ack), .out_wr_ack(out_wr_ack),
`ifdef DRAM_REP_BEAT_CNT_EN
    .beat_cnt(beat_cnt), .mecc_cnt(mecc_cnt),
`endif
    .seq_err(seq_err)
  );

  always #5 rclk = ~rclk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
    logic [ECC_W-1:0]  ecc;
    logic [CW-1:0]     chunk;
    logic [2:0]        id;
    logic              secc, mecc, rd, wr;
  } beat_t;

  beat_t             pipe_q[$];
  logic              m_vld, m_secc, m_mecc, m_rd, m_wr, m_seq_err;
  logic [DATA_W-1:0] m_data;
  logic [ECC_W-1:0]  m_ecc;
  logic [CW-1:0]     m_chunk;
  logic [2:0]        m_id;
  bit                m_in_burst;
  int                m_exp, m_cap;
  int                m_beat_cnt, m_mecc_cnt;

  wire [VW-1:0] m_vec   = {m_vld, m_data, m_ecc, m_chunk, m_id, m_secc, m_mecc, m_rd, m_wr, m_seq_err};
  wire [VW-1:0] dut_vec = {out_vld, out_data, out_ecc, out_chunk_id, out_req_id,
                           out_secc_err, out_mecc_err, out_rd_ack, out_wr_ack, seq_err};

  task automatic model_reset();
    pipe_q.delete();
    for (int i = 0; i < DEPTH; i++) pipe_q.push_back('0);
    {m_vld, m_data, m_ecc, m_chunk, m_id, m_secc, m_mecc, m_rd, m_wr, m_seq_err} = '0;
    m_in_burst = 0; m_exp = 0; m_cap = 0;
    m_beat_cnt = 0; m_mecc_cnt = 0;
  endtask

  task automatic model_edge();
    bit    v;
    beat_t b, f;
    v = 0;
    if (m_vld) begin
      if (!m_in_burst) begin
        if (m_chunk == 0) begin m_cap = m_id; m_exp = 1; m_in_burst = 1; end
        else v = 1;
      end else if (m_chunk == m_exp && m_id == m_cap) begin
        if (m_exp == BEATS - 1) m_in_burst = 0;
        else m_exp = m_exp + 1;
      end else begin
        v = 1;
        if (m_chunk == 0) begin m_cap = m_id; m_exp = 1; end
        else m_in_burst = 0;
      end
    end
    if (v) m_seq_err = 1'b1;
    else if (seq_err_clr) m_seq_err = 1'b0;
    if (seq_err_clr) begin
      m_beat_cnt = 0; m_mecc_cnt = 0;
    end else begin
      if (m_vld && m_beat_cnt < 65535) m_beat_cnt++;
      if (m_mecc && m_mecc_cnt < 65535) m_mecc_cnt++;
    end
    b = '{vld: in_vld, data: in_data, ecc: in_ecc, chunk: in_chunk_id, id: in_req_id,
          secc: in_secc_err, mecc: in_mecc_err, rd: in_rd_ack, wr: in_wr_ack};
    pipe_q.push_back(b);
    if (pipe_q.size() > DEPTH) void'(pipe_q.pop_front());
    f = pipe_q[0];
    m_vld = f.vld; m_rd = f.rd; m_wr = f.wr;
    m_secc = f.vld & f.secc;
    m_mecc = f.vld & f.mecc;
    if (f.vld) begin
      m_data = f.data; m_ecc = f.ecc; m_chunk = f.chunk; m_id = f.id;
    end
  endtask

  task automatic cycle();
    @(posedge rclk);
    if (arst) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    in_vld = 0; in_secc_err = 0; in_mecc_err = 0;
    in_rd_ack = 0; in_wr_ack = 0; seq_err_clr = 0;
  endtask

  task automatic beat(input int chunk, input int id);
    in_vld = 1; in_chunk_id = CW'(chunk); in_req_id = 3'(id);
    in_data = {4{$urandom}}; in_ecc = ECC_W'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    arst = 1; idle_inputs();
    in_data = '1; in_ecc = '1; in_chunk_id = '1; in_req_id = '1;
    cycle(); cycle();
    checks++;
    if (dut_vec !== '0) begin
      errors++; $display("FAIL reset_state: got %h want 0", dut_vec);
    end
    #2 arst = 0;
    model_reset();
  endtask

  task automatic test_latency();
    in_vld = 1; in_data = {16{8'hA5}}; in_ecc = '0; in_chunk_id = 0; in_req_id = 0; in_rd_ack = 1;
    cycle();
    idle_inputs();
    checks++;
    if (out_vld !== 1'b0 || out_rd_ack !== 1'b0) begin
      errors++; $display("FAIL latency_early: got vld=%b ack=%b want 0 0", out_vld, out_rd_ack);
    end
    cycle();
    checks++;
    if (out_vld !== 1'b1 || out_data !== {16{8'hA5}} || out_rd_ack !== 1'b1) begin
      errors++; $display("FAIL latency_depth: got vld=%b ack=%b data=%h", out_vld, out_rd_ack, out_data);
    end
    checks++;
    if (dut_vec !== m_vec) begin
      errors++; $display("FAIL latency_model: got %h want %h", dut_vec, m_vec);
    end
    // Remaining chunks keep the checker happy.
    for (int c = 1; c < BEATS; c++) begin beat(c, 0); cycle(); end
    idle_inputs(); cycle(); cycle();
  endtask

  task automatic test_valid_gating();
    beat(0, 1); in_data = 128'h1234; in_mecc_err = 1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      idle_inputs(); in_mecc_err = 1; in_secc_err = 1;
      in_data = ~in_data;
      cycle();
      if (i >= DEPTH - 1) begin
        checks++;
        if (out_data !== 128'h1234 || out_vld !== 1'b0 || out_mecc_err !== 1'b0 || out_secc_err !== 1'b0) begin
          errors++;
          $display("FAIL valid_gating: got data=%h vld=%b mecc=%b secc=%b want 1234 0 0 0",
                   out_data, out_vld, out_mecc_err, out_secc_err);
        end
      end
    end
    idle_inputs();
    // Finish the burst started above.
    for (int c = 1; c < BEATS; c++) begin beat(c, 1); cycle(); end
    idle_inputs(); cycle(); cycle();
    checks++;
    if (dut_vec !== m_vec) begin
      errors++; $display("FAIL gating_model: got %h want %h", dut_vec, m_vec);
    end
  endtask

  task automatic test_good_burst();
    beat(0, 5); cycle();
    beat(1, 5); cycle();
    idle_inputs(); cycle();
    beat(2, 5); cycle();
    beat(3, 5); cycle();
    for (int c = 0; c < BEATS; c++) begin beat(c, 2); cycle(); end
    idle_inputs();
    for (int i = 0; i < DEPTH + 2; i++) begin
      cycle();
      checks++;
      if (seq_err !== 1'b0 || dut_vec !== m_vec) begin
        errors++; $display("FAIL good_burst: seq_err=%b got %h want %h", seq_err, dut_vec, m_vec);
      end
    end
  endtask

  task automatic test_order_violation();
    beat(0, 3); cycle();
    beat(2, 3); cycle();
    idle_inputs();
    for (int i = 1; i < DEPTH; i++) cycle();
    checks++;
    if (seq_err !== 1'b0) begin
      errors++; $display("FAIL viol_early: got seq_err=%b want 0", seq_err);
    end
    cycle();
    checks++;
    if (seq_err !== 1'b1) begin
      errors++; $display("FAIL viol_set: got seq_err=%b want 1", seq_err);
    end
    seq_err_clr = 1; cycle(); seq_err_clr = 0;
    checks++;
    if (seq_err !== 1'b0) begin
      errors++; $display("FAIL viol_clear: got seq_err=%b want 0", seq_err);
    end
    beat(1, 6); cycle();
    idle_inputs();
    for (int i = 1; i < DEPTH; i++) cycle();
    seq_err_clr = 1; cycle(); seq_err_clr = 0;
    checks++;
    if (seq_err !== 1'b1 || dut_vec !== m_vec) begin
      errors++; $display("FAIL clr_vs_set: got seq_err=%b vec %h want %h", seq_err, dut_vec, m_vec);
    end
    seq_err_clr = 1; cycle(); seq_err_clr = 0;
  endtask

  task automatic test_reset_mid_burst();
    beat(0, 4); in_rd_ack = 1; cycle();
    beat(1, 4); in_mecc_err = 1; cycle();
    idle_inputs();
    #2 arst = 1;
    #1;
    checks++;
    if (dut_vec !== '0) begin
      errors++; $display("FAIL async_reset: got %h want 0", dut_vec);
    end
    model_reset();
    #1 arst = 0;
    for (int c = 0; c < BEATS; c++) begin beat(c, 1); cycle(); end
    idle_inputs();
    for (int i = 0; i < DEPTH + 1; i++) cycle();
    checks++;
    if (seq_err !== 1'b0 || dut_vec !== m_vec) begin
      errors++; $display("FAIL post_reset: seq_err=%b got %h want %h", seq_err, dut_vec, m_vec);
    end
  endtask

  task automatic test_random();
    int gc, gid;
    gc = 0; gid = 0;
    for (int n = 0; n < 2500; n++) begin
      in_vld      = ($urandom % 4) != 0;
      in_data     = {4{$urandom}};
      in_ecc      = ECC_W'($urandom);
      in_secc_err = $urandom % 2;
      in_mecc_err = $urandom % 2;
      in_rd_ack   = $urandom % 2;
      in_wr_ack   = $urandom % 2;
      seq_err_clr = ($urandom % 16) == 0;
      if (($urandom % 20) == 0) begin
        in_chunk_id = CW'($urandom); in_req_id = 3'($urandom);
      end else begin
        in_chunk_id = CW'(gc); in_req_id = 3'(gid);
      end
      if (in_vld) begin
        gc = (gc + 1) % BEATS;
        if (gc == 0) gid = $urandom % 8;
      end
      cycle();
      checks++;
      if (dut_vec !== m_vec) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", n, dut_vec, m_vec);
      end
    end
    idle_inputs();
    seq_err_clr = 1; cycle(); cycle(); cycle(); seq_err_clr = 0;
  endtask

`ifdef DRAM_REP_BEAT_CNT_EN
  task automatic test_counters();
    for (int n = 0; n < 70000; n++) begin
      beat(n % BEATS, 7); in_mecc_err = 1;
      cycle();
    end
    idle_inputs();
    cycle(); cycle();
    checks++;
    if (beat_cnt !== 16'hFFFF || mecc_cnt !== 16'hFFFF ||
        beat_cnt !== 16'(m_beat_cnt) || mecc_cnt !== 16'(m_mecc_cnt)) begin
      errors++; $display("FAIL cnt_saturate: got beat=%h mecc=%h want ffff ffff", beat_cnt, mecc_cnt);
    end
    seq_err_clr = 1; cycle(); seq_err_clr = 0;
    checks++;
    if (beat_cnt !== 16'h0 || mecc_cnt !== 16'h0) begin
      errors++; $display("FAIL cnt_clear: got beat=%h mecc=%h want 0 0", beat_cnt, mecc_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_valid_gating();
    test_good_burst();
    test_order_violation();
    test_reset_mid_burst();
    test_random();
`ifdef DRAM_REP_BEAT_CNT_EN
    test_counters();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
